lsu_sequencer: RTL and testbench

- Multi-cycle load/store sequencer between the execute stage and a req/gnt/rvalid data-memory bus.
- Takes the control unit's per-instruction memory controls (dmem_req, dmem_size, dmem_wr_en, dmem_zero_extend) plus the address and store data. Drives the bus and stalls the core until the access completes.
- Produces aligned and extended load data for writeback, and flags misaligned accesses and bus timeouts.

---
 rtl/lsu_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_lsu_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_sequencer.sv
// lsu_sequencer: multi-cycle load/store sequencer between execute and a req/gnt/rvalid data bus.
// Define LSU_MISALIGNED_SPLIT_EN to run misaligned half/word accesses as two word-bus beats.
module lsu_sequencer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_req,
  input  logic        ex_wr_en,
  input  logic [1:0]  ex_size,
  input  logic        ex_zero_extend,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  output logic        stall,
  output logic        wb_valid,
  output logic [31:0] wb_rdata,
  output logic        misaligned,
  output logic        bus_err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);
  // state | meaning
  // IDLE  | waiting for a memory instruction
  // REQ   | request on the bus, waiting for gnt
  // WAIT  | granted, waiting for rvalid
  // DONE  | one-cycle completion pulse
  // REQ2  | second beat request (split build only)
  // WAIT2 | second beat response (split build only)
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
`ifdef LSU_MISALIGNED_SPLIT_EN
  localparam logic [2:0] S_REQ2  = 3'd4;
  localparam logic [2:0] S_WAIT2 = 3'd5;
  localparam int MW = 8;
`else
  localparam int MW = 4;
`endif
  localparam int CW = $clog2(TIMEOUT_CYCLES + 2);
  localparam int TO_LIM = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [1:0]    off_q, size_q;
  logic          zext_q;
  logic [1:0]    off;
  logic          mis, busy, timeout;
  logic [MW-1:0] mask;
  logic [31:0]   wrep, ld1;

  assign off = ex_addr[1:0];
  assign mis = ((ex_size == 2'd1) && off[0]) || (ex_size[1] && (off != 2'b00));

  always_comb begin
    mask = MW'(4'hF) << off;
    wrep = ex_wdata;
    case (ex_size)
      2'd0: begin mask = MW'(4'h1) << off; wrep = {4{ex_wdata[7:0]}}; end
      2'd1: begin mask = MW'(4'h3) << off; wrep = {2{ex_wdata[15:0]}}; end
      default: ;
    endcase
  end

  function automatic logic [31:0] extend(input logic [31:0] sh, input logic [1:0] sz, input logic zx);
    case (sz)
      2'd0:    extend = {{24{~zx & sh[7]}}, sh[7:0]};
      2'd1:    extend = {{16{~zx & sh[15]}}, sh[15:0]};
      default: extend = sh;
    endcase
  endfunction

  assign ld1 = mem_rdata >> {off_q, 3'b000};

`ifdef LSU_MISALIGNED_SPLIT_EN
  logic        split_q;
  logic [31:0] rdata1_q, wdata_hi_q;
  logic [3:0]  be_hi_q;
  logic [63:0] wwide, ld2_wide;
  assign wwide    = {32'b0, wrep} << {off, 3'b000};
  assign ld2_wide = {mem_rdata, rdata1_q} >> {off_q, 3'b000};
  assign busy     = (state == S_REQ) || (state == S_WAIT) || (state == S_REQ2) || (state == S_WAIT2);
  assign mem_req  = (state == S_REQ) || (state == S_REQ2);
`else
  assign busy     = (state == S_REQ) || (state == S_WAIT);
  assign mem_req  = (state == S_REQ);
`endif

  assign timeout  = (TIMEOUT_CYCLES != 0) && busy && (cnt >= CW'(TO_LIM));
  assign stall    = ~reset & (((state == S_IDLE) & ex_req) | busy);
  assign wb_valid = (state == S_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      off_q      <= '0;
      size_q     <= '0;
      zext_q     <= 1'b0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      mem_wdata  <= '0;
      wb_rdata   <= '0;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
`ifdef LSU_MISALIGNED_SPLIT_EN
      split_q    <= 1'b0;
      rdata1_q   <= '0;
      wdata_hi_q <= '0;
      be_hi_q    <= '0;
`endif
    end else begin
      // result flags live only for the DONE cycle
      wb_rdata   <= '0;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
      cnt        <= busy ? cnt + 1'b1 : '0;
      case (state)
        S_IDLE: if (ex_req) begin
`ifndef LSU_MISALIGNED_SPLIT_EN
          if (mis) begin
            state      <= S_DONE;
            misaligned <= 1'b1;
          end else
`endif
          begin
            state    <= S_REQ;
            mem_addr <= {ex_addr[31:2], 2'b00};
            mem_we   <= ex_wr_en;
            mem_be   <= mask[3:0];
            off_q    <= off;
            size_q   <= ex_size;
            zext_q   <= ex_zero_extend;
`ifdef LSU_MISALIGNED_SPLIT_EN
            split_q    <= mis;
            mem_wdata  <= mis ? wwide[31:0] : wrep;
            be_hi_q    <= mask[7:4];
            wdata_hi_q <= wwide[63:32];
`else
            mem_wdata  <= wrep;
`endif
          end
        end
        S_REQ:
          if (mem_gnt) state <= S_WAIT;
          else if (timeout) begin state <= S_DONE; bus_err <= 1'b1; end
        S_WAIT:
          if (mem_rvalid) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
            if (split_q) begin
              state     <= S_REQ2;
              rdata1_q  <= mem_rdata;
              mem_addr  <= mem_addr + 32'd4;
              mem_be    <= be_hi_q;
              mem_wdata <= wdata_hi_q;
            end else
`endif
            begin
              state <= S_DONE;
              if (!mem_we) wb_rdata <= extend(ld1, size_q, zext_q);
            end
          end else if (timeout) begin state <= S_DONE; bus_err <= 1'b1; end
`ifdef LSU_MISALIGNED_SPLIT_EN
        S_REQ2:
          if (mem_gnt) state <= S_WAIT2;
          else if (timeout) begin state <= S_DONE; bus_err <= 1'b1; end
        S_WAIT2:
          if (mem_rvalid) begin
            state <= S_DONE;
            if (!mem_we) wb_rdata <= extend(ld2_wide[31:0], size_q, zext_q);
          end else if (timeout) begin state <= S_DONE; bus_err <= 1'b1; end
`endif
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_sequencer.sv
// tb_lsu_sequencer: directed, cycle-scripted checks of lsu_sequencer with TIMEOUT_CYCLES = 8.
module tb_lsu_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic        ex_req, ex_wr_en, ex_zero_extend;
  logic [1:0]  ex_size;
  logic [31:0] ex_addr, ex_wdata;
  logic        stall, wb_valid, misaligned, bus_err;
  logic [31:0] wb_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_sequencer #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .ex_req(ex_req), .ex_wr_en(ex_wr_en), .ex_size(ex_size),
    .ex_zero_extend(ex_zero_extend), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .stall(stall), .wb_valid(wb_valid), .wb_rdata(wb_rdata),
    .misaligned(misaligned), .bus_err(bus_err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " wb_valid"}, 32'(wb_valid), 32'd0);
    check({tag, " wb_rdata"}, wb_rdata, 32'd0);
    check({tag, " mem_req"}, 32'(mem_req), 32'd0);
    check({tag, " misaligned"}, 32'(misaligned), 32'd0);
    check({tag, " bus_err"}, 32'(bus_err), 32'd0);
  endtask

  task automatic issue(input logic wr, input logic [1:0] sz, input logic zx,
                       input logic [31:0] a, input logic [31:0] wd);
    step();
    ex_req = 1'b1; ex_wr_en = wr; ex_size = sz; ex_zero_extend = zx; ex_addr = a; ex_wdata = wd;
    #1;
    check("idle stall", 32'(stall), 32'd1);
    check("idle mem_req", 32'(mem_req), 32'd0);
  endtask

  task automatic bus_beat(input string tag, input int gnt_dly, input int rv_dly, input logic [31:0] rd,
                          input logic [31:0] e_addr, input logic [3:0] e_be, input logic e_we,
                          input logic [31:0] e_wd);
    for (int i = 0; i <= gnt_dly; i++) begin
      step();
      mem_gnt = (i == gnt_dly);
      #1;
      check({tag, " mem_req"}, 32'(mem_req), 32'd1);
      check({tag, " mem_addr"}, mem_addr, e_addr);
      check({tag, " mem_be"}, 32'(mem_be), 32'(e_be));
      check({tag, " mem_we"}, 32'(mem_we), 32'(e_we));
      if (e_we) check({tag, " mem_wdata"}, mem_wdata, e_wd);
      check({tag, " stall req"}, 32'(stall), 32'd1);
    end
    for (int j = 0; j <= rv_dly; j++) begin
      step();
      mem_gnt = 1'b0;
      mem_rvalid = (j == rv_dly);
      mem_rdata = rd;
      #1;
      check({tag, " mem_req wait"}, 32'(mem_req), 32'd0);
      check({tag, " stall wait"}, 32'(stall), 32'd1);
      check({tag, " wb_valid wait"}, 32'(wb_valid), 32'd0);
    end
  endtask

  task automatic finish_done(input string tag, input logic [31:0] e_rd);
    step();
    mem_rvalid = 1'b0;
    #1;
    check({tag, " wb_valid"}, 32'(wb_valid), 32'd1);
    check({tag, " wb_rdata"}, wb_rdata, e_rd);
    check({tag, " stall done"}, 32'(stall), 32'd0);
    check({tag, " misaligned"}, 32'(misaligned), 32'd0);
    check({tag, " bus_err"}, 32'(bus_err), 32'd0);
    step();
    ex_req = 1'b0;
    #1;
    check_quiet({tag, " after"});
  endtask

  task automatic run_access(input string tag, input logic wr, input logic [1:0] sz, input logic zx,
                            input logic [31:0] a, input logic [31:0] wd, input int gnt_dly,
                            input int rv_dly, input logic [31:0] rd, input logic [31:0] e_addr,
                            input logic [3:0] e_be, input logic [31:0] e_wd, input logic [31:0] e_rd);
    issue(wr, sz, zx, a, wd);
    bus_beat(tag, gnt_dly, rv_dly, rd, e_addr, e_be, wr, e_wd);
    finish_done(tag, e_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ex_req = 1'b0; ex_wr_en = 1'b0; ex_size = 2'd0; ex_zero_extend = 1'b0;
    ex_addr = '0; ex_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    #2;
    check_quiet("reset");
    check("reset stall", 32'(stall), 32'd0);
    check("reset mem_addr", mem_addr, 32'd0);
    check("reset mem_be", 32'(mem_be), 32'd0);
    check("reset mem_wdata", mem_wdata, 32'd0);
    check("reset mem_we", 32'(mem_we), 32'd0);
    step(); step();
    reset = 1'b0;

    // tag, wr, size, zext, addr, wdata, gnt_dly, rv_dly, rdata, exp addr, be, wdata, rdata
    run_access("lb_sext",  1'b0, 2'd0, 1'b0, 32'h0000_1003, 32'h0, 0, 1, 32'h8000_0000,
               32'h0000_1000, 4'b1000, 32'h0, 32'hFFFF_FF80);
    run_access("sh",       1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'h0000_BEEF, 0, 0, 32'h1234_5678,
               32'h0000_2000, 4'b1100, 32'hBEEF_BEEF, 32'h0);
    run_access("lw_gnt5",  1'b0, 2'd2, 1'b0, 32'h0000_3000, 32'h0, 5, 0, 32'hDEAD_BEEF,
               32'h0000_3000, 4'b1111, 32'h0, 32'hDEAD_BEEF);
    run_access("lhu_hi",   1'b0, 2'd1, 1'b1, 32'h0000_5002, 32'h0, 1, 2, 32'h8001_0000,
               32'h0000_5000, 4'b1100, 32'h0, 32'h0000_8001);
    run_access("lh_lo",    1'b0, 2'd1, 1'b0, 32'h0000_5000, 32'h0, 0, 0, 32'h0000_F00F,
               32'h0000_5000, 4'b0011, 32'h0, 32'hFFFF_F00F);
    run_access("lbu_1",    1'b0, 2'd0, 1'b1, 32'h0000_5001, 32'h0, 0, 0, 32'h0000_AB00,
               32'h0000_5000, 4'b0010, 32'h0, 32'h0000_00AB);
    run_access("sb_1",     1'b1, 2'd0, 1'b0, 32'h0000_6001, 32'h0000_00A5, 0, 0, 32'hFFFF_FFFF,
               32'h0000_6000, 4'b0010, 32'hA5A5_A5A5, 32'h0);
    run_access("sw",       1'b1, 2'd2, 1'b0, 32'h0000_7000, 32'h0102_0304, 2, 1, 32'h0,
               32'h0000_7000, 4'b1111, 32'h0102_0304, 32'h0);

    // timeout: 8 cycles in REQ without gnt, then a stray rvalid
    issue(1'b0, 2'd2, 1'b0, 32'h0000_8000, 32'h0);
    for (int i = 0; i < 8; i++) begin
      step();
      check("to mem_req", 32'(mem_req), 32'd1);
      check("to mem_addr", mem_addr, 32'h0000_8000);
    end
    step();
    check("to bus_err", 32'(bus_err), 32'd1);
    check("to wb_valid", 32'(wb_valid), 32'd1);
    check("to wb_rdata", wb_rdata, 32'd0);
    check("to mem_req drop", 32'(mem_req), 32'd0);
    step();
    ex_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    #1;
    check_quiet("to late rvalid");
    step();
    mem_rvalid = 1'b0;
    #1;
    check_quiet("to idle");
    check("to idle stall", 32'(stall), 32'd0);

`ifdef LSU_MISALIGNED_SPLIT_EN
    issue(1'b0, 2'd2, 1'b0, 32'h0000_4001, 32'h0);
    bus_beat("split1", 0, 0, 32'h4433_2211, 32'h0000_4000, 4'b1110, 1'b0, 32'h0);
    bus_beat("split2", 0, 0, 32'h8877_6655, 32'h0000_4004, 4'b0001, 1'b0, 32'h0);
    finish_done("split", 32'h5544_3322);
`else
    issue(1'b0, 2'd2, 1'b0, 32'h0000_4001, 32'h0);
    step();
    check("mis_lw misaligned", 32'(misaligned), 32'd1);
    check("mis_lw wb_valid", 32'(wb_valid), 32'd1);
    check("mis_lw mem_req", 32'(mem_req), 32'd0);
    check("mis_lw stall", 32'(stall), 32'd0);
    check("mis_lw wb_rdata", wb_rdata, 32'd0);
    step();
    ex_req = 1'b0;
    #1;
    check_quiet("mis_lw after");
    issue(1'b1, 2'd1, 1'b0, 32'h0000_4003, 32'h0000_1234);
    step();
    check("mis_sh misaligned", 32'(misaligned), 32'd1);
    check("mis_sh mem_req", 32'(mem_req), 32'd0);
    step();
    ex_req = 1'b0;
    #1;
    check_quiet("mis_sh after");
`endif

    // reset while waiting for rvalid on a store
    issue(1'b1, 2'd2, 1'b0, 32'h0000_9000, 32'hCAFE_F00D);
    step();
    mem_gnt = 1'b1;
    #1;
    check("rst mem_wdata", mem_wdata, 32'hCAFE_F00D);
    step();
    mem_gnt = 1'b0;
    #1;
    check("rst wait stall", 32'(stall), 32'd1);
    reset = 1'b1;
    #1;
    check_quiet("rst async");
    check("rst stall", 32'(stall), 32'd0);
    check("rst mem_addr", mem_addr, 32'd0);
    check("rst mem_we", 32'(mem_we), 32'd0);
    check("rst mem_be", 32'(mem_be), 32'd0);
    check("rst mem_wdata0", mem_wdata, 32'd0);
    step();
    reset = 1'b0; ex_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
    step();
    mem_rvalid = 1'b0;
    #1;
    check_quiet("rst rvalid ignored");
    step();
    check_quiet("rst idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
